// File: rtl/downsizing.sv
// AXI-Stream width converter: each 2*W-bit beat leaves as its upper W-bit word,
// then its lower word unless the beat is marked single. This is the inverse of upsizing.
module downsizing #(
   parameter int W = 40
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [2*W-1:0]   in_tdata,
   input  logic             in_tvalid,
   output logic             in_tready,
   input  logic             in_tsingle,
   input  logic             in_tlast,
   output logic [W-1:0]     out_tdata,
   output logic             out_tvalid,
   input  logic             out_tready,
   output logic             out_tlast,
   output logic [1:0]       dbg_state
);

   // Handshakes: a beat moves on a rising edge where valid & ready are both high.
   // Once valid rises, it and its payload hold until that edge. in_tready never
   // depends on in_tvalid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      UPPER = 2'd1,
      LOWER = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [2*W-1:0]   held_data;
   logic             held_single;
   logic             held_last;
   logic             wide_xfer;

   assign wide_xfer = in_tvalid & in_tready;
   assign dbg_state = state_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   // The holding register carries no reset; it is only read outside EMPTY.
   always_ff @(posedge aclk) begin
      if (wide_xfer) begin
         held_data   <= in_tdata;
         held_single <= in_tsingle;
         held_last   <= in_tlast;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (wide_xfer) state_d = UPPER;
         UPPER: if (out_tready) state_d = held_single ? EMPTY : LOWER;
         LOWER: if (out_tready) state_d = wide_xfer ? UPPER : EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // In LOWER, in_tready follows out_tready so a new beat loads as the lower word leaves.
   always_comb begin
      in_tready  = 1'b0;
      out_tvalid = 1'b0;
      out_tdata  = held_data[2*W-1:W];
      out_tlast  = 1'b0;
      case (state_q)
         EMPTY: in_tready = aresetn;
         UPPER: begin
            out_tvalid = 1'b1;
            out_tlast  = held_single & held_last;
         end
         LOWER: begin
            in_tready  = out_tready & aresetn;
            out_tvalid = 1'b1;
            out_tdata  = held_data[W-1:0];
            out_tlast  = held_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_downsizing.sv
// Bench for downsizing: directed timing steps plus randomized traffic checked by a
// queue-based reference model of the narrow word stream.
module tb_downsizing;

   localparam int W = 40;

   logic             aclk;
   logic             aresetn;
   logic [2*W-1:0]   in_tdata;
   logic             in_tvalid;
   logic             in_tready;
   logic             in_tsingle;
   logic             in_tlast;
   logic [W-1:0]     out_tdata;
   logic             out_tvalid;
   logic             out_tready;
   logic             out_tlast;
   logic [1:0]       dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [W:0]       exp_q[$];
   logic [2*W-1:0]   beats [3];
   logic [W-1:0]     words [6];
   logic             done;

   logic             prev_stall;
   logic [W-1:0]     prev_data;
   logic             prev_last;

   downsizing #(.W(W)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .in_tsingle (in_tsingle),
      .in_tlast   (in_tlast),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tlast  (out_tlast),
      .dbg_state  (dbg_state)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: every accepted wide beat becomes its upper word, then its
   // lower word unless single; last marks the final word emitted for that beat.
   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 80'(out_tvalid), 80'(1'b1));
            check("stall_data", 80'(out_tdata), 80'(prev_data));
            check("stall_last", 80'(out_tlast), 80'(prev_last));
         end
         if (in_tvalid && in_tready) begin
            exp_q.push_back({in_tsingle & in_tlast, in_tdata[2*W-1:W]});
            if (!in_tsingle) exp_q.push_back({in_tlast, in_tdata[W-1:0]});
         end
         if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_word", 80'(out_tdata), 80'(0));
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               check("sb_data", 80'(out_tdata), 80'(e[W-1:0]));
               check("sb_last", 80'(out_tlast), 80'(e[W]));
            end
         end
         prev_stall = out_tvalid & ~out_tready;
         prev_data  = out_tdata;
         prev_last  = out_tlast;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
   task automatic send_beat(input logic [2*W-1:0] d, input logic s, input logic l);
      int t;
      t = 0;
      in_tdata   = d;
      in_tsingle = s;
      in_tlast   = l;
      in_tvalid  = 1'b1;
      @(negedge aclk);
      while (!in_tready && t < 200) begin
         t++;
         @(negedge aclk);
      end
      check("send_timeout", 80'(t < 200), 80'(1'b1));
      @(posedge aclk); #1;
      in_tvalid = 1'b0;
      in_tdata  = {$urandom(), $urandom(), 16'(W)};
   endtask

   task automatic drain_and_stop();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(posedge aclk); #1;
         t++;
      end
      check("drain_timeout", 80'(exp_q.size()), 80'(0));
      done = 1'b1;
   endtask

   task automatic drive_ready(input int mode);
      int k;
      k = 0;
      while (!done) begin
         case (mode)
            0:       out_tready = (k % 2 == 0);
            1:       out_tready = (k % 2 == 1);
            default: out_tready = 1'($urandom_range(0, 1));
         endcase
         k++;
         @(posedge aclk); #1;
      end
      out_tready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2*W-1:0] rnd;
      beats[0] = "ABCDEFGHIJ";
      beats[1] = "KLMONPQRST";
      beats[2] = "UVWXYZabcd";
      words[0] = "ABCDE"; words[1] = "FGHIJ"; words[2] = "KLMON";
      words[3] = "PQRST"; words[4] = "UVWXY"; words[5] = "Zabcd";
      done       = 1'b0;
      aresetn    = 1'b0;
      in_tdata   = '0;
      in_tvalid  = 1'b0;
      in_tsingle = 1'b0;
      in_tlast   = 1'b0;
      out_tready = 1'b1;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;

      // Reset state
      #1;
      check("rst_out_tvalid", 80'(out_tvalid), 80'(1'b0));
      check("rst_out_tlast", 80'(out_tlast), 80'(1'b0));
      check("rst_in_tready", 80'(in_tready), 80'(1'b0));
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(negedge aclk);
      check("post_rst_in_tready", 80'(in_tready), 80'(1'b1));
      @(posedge aclk); #1;

      // Back-to-back
      for (int i = 0; i < 7; i++) begin
         in_tvalid = (i < 6);
         in_tdata  = (i < 6) ? beats[i/2] : '0;
         @(negedge aclk);
         if (i < 6) check("b2b_in_tready", 80'(in_tready), 80'(i % 2 == 0));
         check("b2b_out_tvalid", 80'(out_tvalid), 80'(i > 0));
         if (i > 0) check("b2b_out_tdata", 80'(out_tdata), 80'(words[i-1]));
         @(posedge aclk); #1;
      end
      in_tvalid = 1'b0;

      // Gaps in valid
      for (int i = 0; i < 9; i++) begin
         in_tvalid = (i % 3 == 0);
         in_tdata  = beats[i/3];
         @(negedge aclk);
         check("gap_out_tvalid", 80'(out_tvalid), 80'(i % 3 != 0));
         if (i % 3 != 0) check("gap_out_tdata", 80'(out_tdata), 80'(words[(i/3)*2 + (i%3) - 1]));
         @(posedge aclk); #1;
      end
      in_tvalid = 1'b0;

      // Output stall while holding the upper half
      in_tvalid = 1'b1;
      in_tdata  = beats[0];
      @(negedge aclk);
      check("stall_accept", 80'(in_tready), 80'(1'b1));
      @(posedge aclk); #1;
      in_tvalid  = 1'b0;
      out_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         check("stall_hold_data", 80'(out_tdata), 80'(words[0]));
         check("stall_hold_valid", 80'(out_tvalid), 80'(1'b1));
         check("stall_in_tready", 80'(in_tready), 80'(1'b0));
         @(posedge aclk); #1;
      end
      out_tready = 1'b1;
      @(negedge aclk);
      check("stall_release_upper", 80'(out_tdata), 80'(words[0]));
      @(posedge aclk); #1;
      @(negedge aclk);
      check("stall_release_lower", 80'(out_tdata), 80'(words[1]));
      @(posedge aclk); #1;

      // Single and last
      in_tvalid  = 1'b1;
      in_tdata   = {words[2], 40'h78_78_78_78_78};
      in_tsingle = 1'b1;
      in_tlast   = 1'b1;
      @(negedge aclk);
      check("single_accept", 80'(in_tready), 80'(1'b1));
      @(posedge aclk); #1;
      in_tdata   = "PQRSTUVWXY";
      in_tsingle = 1'b0;
      in_tlast   = 1'b0;
      @(negedge aclk);
      check("single_upper", 80'(out_tdata), 80'(words[2]));
      check("single_last", 80'(out_tlast), 80'(1'b1));
      check("single_in_tready", 80'(in_tready), 80'(1'b0));
      @(posedge aclk); #1;
      @(negedge aclk);
      check("single_no_lower", 80'(out_tvalid), 80'(1'b0));
      check("single_empty_ready", 80'(in_tready), 80'(1'b1));
      @(posedge aclk); #1;
      in_tvalid = 1'b0;
      @(negedge aclk);
      check("single_next_upper", 80'(out_tdata), 80'(words[3]));
      check("single_next_last", 80'(out_tlast), 80'(1'b0));
      @(posedge aclk); #1;
      @(negedge aclk);
      check("single_next_lower", 80'(out_tdata), 80'(words[4]));
      @(posedge aclk); #1;

      // Ready patterns: toggle from 1, toggle from 0, random
      for (int mode = 0; mode < 3; mode++) begin
         done = 1'b0;
         fork
            begin
               for (int r = 0; r < 3; r++)
                  for (int b = 0; b < 3; b++) send_beat(beats[b], 1'b0, 1'b0);
               drain_and_stop();
            end
            drive_ready(mode);
         join
      end

      // Random traffic: data, single, last, valid gaps and ready all randomized
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 60; n++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge aclk); #1;
               end
               rnd = {$urandom(), $urandom(), 16'($urandom())};
               send_beat(rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            drain_and_stop();
         end
         drive_ready(2);
      join

      // Reset mid-operation, asserted while the lower half is on the output
      in_tsingle = 1'b0;
      in_tlast   = 1'b0;
      in_tvalid  = 1'b1;
      in_tdata   = beats[0];
      @(posedge aclk); #1;
      in_tvalid = 1'b0;
      @(posedge aclk); #1;
      check("rst_mid_lower", 80'(out_tdata), 80'(words[1]));
      #2 aresetn = 1'b0;
      #1;
      check("rst_mid_out_tvalid", 80'(out_tvalid), 80'(1'b0));
      check("rst_mid_in_tready", 80'(in_tready), 80'(1'b0));
      check("rst_mid_out_tlast", 80'(out_tlast), 80'(1'b0));
      exp_q.delete();
      @(negedge aclk);
      check("rst_hold_in_tready", 80'(in_tready), 80'(1'b0));
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_release_in_tready", 80'(in_tready), 80'(1'b1));
      check("rst_release_out_tvalid", 80'(out_tvalid), 80'(1'b0));
      @(posedge aclk); #1;
      in_tvalid = 1'b1;
      in_tdata  = beats[0];
      @(posedge aclk); #1;
      in_tvalid = 1'b0;
      @(negedge aclk);
      check("rst_first_word", 80'(out_tdata), 80'(words[0]));
      @(posedge aclk); #1;
      done = 1'b0;
      drain_and_stop();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
